// File: rtl/int_ctrl.sv
// int_ctrl: 8051-style interrupt controller.
// Owns the IE0/TF0/IE1/TF1 request flags, arbitrates five sources over two
// priority levels with in-service nesting, and runs the irq/ack/RETI handshake.
// Build option: define INT_PIN_SYNC_EN to put a 2-flop synchroniser on the
// int0_n/int1_n pins; without it the pins feed the edge/level logic directly.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no request outstanding; arbitration result taken each cycle
//   REQ   | irq asserted for latched source, waiting for irq_ack
module int_ctrl #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int          VEC_STRIDE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ie,
    input  logic [7:0]  ip,
    input  logic        it0,
    input  logic        it1,
    input  logic        int0_n,
    input  logic        int1_n,
    input  logic        tf0_set,
    input  logic        tf1_set,
    input  logic        ri,
    input  logic        ti,
    input  logic        flag_wr,
    input  logic [3:0]  flag_wdata,
    output logic [3:0]  flags,
    output logic        irq,
    output logic [2:0]  irq_src,
    output logic [15:0] irq_vec,
    input  logic        irq_ack,
    input  logic        reti,
    output logic [1:0]  in_service
);

    typedef enum logic [0:0] {IDLE, REQ} state_t;

    state_t      state;
    logic        irq_lvl;
    logic        pin0_s, pin1_s;
    logic        prev0, prev1;
    logic        fall0, fall1;
    logic        ie0_f, tf0_f, ie1_f, tf1_f;
    logic        ack_take;
    logic        clr_ie0, clr_tf0, clr_ie1, clr_tf1;
    logic [4:0]  req, pending, hi_pend, lo_pend, sel;
    logic        cand_high, eligible, src_pending;
    logic [2:0]  cand_idx;
    logic [15:0] cand_vec;
    logic [1:0]  is_after_reti;

`ifdef INT_PIN_SYNC_EN
    logic [1:0] sync0, sync1;

    // Two-flop synchronisers on the asynchronous external pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0 <= 2'b11;
            sync1 <= 2'b11;
        end else begin
            sync0 <= {sync0[0], int0_n};
            sync1 <= {sync1[0], int1_n};
        end
    end

    assign pin0_s = sync0[1];
    assign pin1_s = sync1[1];
`else
    assign pin0_s = int0_n;
    assign pin1_s = int1_n;
`endif

    // Previous-value registers for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev0 <= 1'b1;
            prev1 <= 1'b1;
        end else begin
            prev0 <= pin0_s;
            prev1 <= pin1_s;
        end
    end

    assign fall0 = prev0 & ~pin0_s;
    assign fall1 = prev1 & ~pin1_s;

    // Level-mode IE flags and serial flags stay set across acknowledge.
    assign ack_take = (state == REQ) && irq_ack;
    assign clr_ie0  = ack_take && (irq_src == 3'd0) && it0;
    assign clr_tf0  = ack_take && (irq_src == 3'd1);
    assign clr_ie1  = ack_take && (irq_src == 3'd2) && it1;
    assign clr_tf1  = ack_take && (irq_src == 3'd3);

    // Request flags: hardware set beats acknowledge clear beats software write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie0_f <= 1'b0;
            tf0_f <= 1'b0;
            ie1_f <= 1'b0;
            tf1_f <= 1'b0;
        end else begin
            if (!it0)         ie0_f <= ~pin0_s;
            else if (fall0)   ie0_f <= 1'b1;
            else if (clr_ie0) ie0_f <= 1'b0;
            else if (flag_wr) ie0_f <= flag_wdata[0];

            if (tf0_set)      tf0_f <= 1'b1;
            else if (clr_tf0) tf0_f <= 1'b0;
            else if (flag_wr) tf0_f <= flag_wdata[1];

            if (!it1)         ie1_f <= ~pin1_s;
            else if (fall1)   ie1_f <= 1'b1;
            else if (clr_ie1) ie1_f <= 1'b0;
            else if (flag_wr) ie1_f <= flag_wdata[2];

            if (tf1_set)      tf1_f <= 1'b1;
            else if (clr_tf1) tf1_f <= 1'b0;
            else if (flag_wr) tf1_f <= flag_wdata[3];
        end
    end

    assign flags = {tf1_f, ie1_f, tf0_f, ie0_f};

    // Arbitration: high level first, lowest index within a level.
    always_comb begin
        req       = {ri | ti, tf1_f, ie1_f, tf0_f, ie0_f};
        pending   = req & ie[4:0] & {5{ie[7]}};
        hi_pend   = pending & ip[4:0];
        lo_pend   = pending & ~ip[4:0];
        cand_high = |hi_pend;
        sel       = cand_high ? hi_pend : lo_pend;
        cand_idx  = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (sel[i]) cand_idx = 3'(i);
        end
        eligible  = (|pending) &&
                    ((in_service == 2'b00) || (cand_high && in_service == 2'b01));
        src_pending = |(pending & (5'b00001 << irq_src));
    end

    assign cand_vec = VEC_BASE + 16'(cand_idx) * 16'(VEC_STRIDE);

    // RETI retires the highest active level; an ack in the same cycle lands after it.
    always_comb begin
        is_after_reti = in_service;
        if (reti) begin
            if (in_service[1])      is_after_reti[1] = 1'b0;
            else if (in_service[0]) is_after_reti[0] = 1'b0;
        end
    end

    // Request/acknowledge sequencer with registered irq outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_src    <= 3'd0;
            irq_vec    <= VEC_BASE;
            irq_lvl    <= 1'b0;
            in_service <= 2'b00;
        end else begin
            in_service <= is_after_reti;
            case (state)
                IDLE: begin
                    if (eligible) begin
                        irq     <= 1'b1;
                        irq_src <= cand_idx;
                        irq_vec <= cand_vec;
                        irq_lvl <= cand_high;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        in_service <= is_after_reti | (irq_lvl ? 2'b10 : 2'b01);
                        irq        <= 1'b0;
                        state      <= IDLE;
                    end else if (!src_pending) begin
                        irq   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
